// File: rtl/ecp3_ddr_clk_init.sv
`default_nettype none
// ============================================================================
//  Module   : ecp3_ddr_clk_init
//  Brief    : Bring-up / recovery sequencer for the DDR clock-sync-alignment
//             block. Waits for PLL+DLL lock, pulses the CSA datapath reset,
//             waits for alignment good, retries on error/timeout and gates
//             DQSDLL code updates (uddcntln) while the datapath is running.
//  Revision : 1.0  initial release
// ============================================================================
module ecp3_ddr_clk_init #(
  parameter int LOCK_STABLE   = 64,
  parameter int RST_CYCLES    = 16,
  parameter int ALIGN_TIMEOUT = 4096,
  parameter int MAX_RETRY     = 3,
  parameter int UPD_CYCLES    = 8
) (
  input  logic       sclk,
  input  logic       reset,
  input  logic       all_lock,
  input  logic       good,
  input  logic       err,
  input  logic       upd_req,
  output logic       reset_datapath,
  output logic       uddcntln,
  output logic       upd_ack,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK  = 3'd0,
    ST_RESET_DP   = 3'd1,
    ST_WAIT_ALIGN = 3'd2,
    ST_RUN        = 3'd3,
    ST_RETRY      = 3'd4,
    ST_FAIL       = 3'd5
  } state_t;

  localparam int WCNT_W = (UPD_CYCLES > 1) ? $clog2(UPD_CYCLES) : 1;

  localparam logic [12:0]       C_LOCK_LAST  = 13'(LOCK_STABLE - 1);
  localparam logic [12:0]       C_RST_LAST   = 13'(RST_CYCLES - 1);
  localparam logic [12:0]       C_ALIGN_LAST = 13'(ALIGN_TIMEOUT - 1);
  localparam logic [3:0]        C_MAX_RETRY  = 4'(MAX_RETRY);
  localparam logic [WCNT_W-1:0] C_UPD_LAST   = WCNT_W'(UPD_CYCLES - 1);

  state_t              state_q, state_d;
  logic [12:0]         cnt_q, cnt_d;
  logic [3:0]          retry_q, retry_d;
  logic [1:0]          lock_sync_q, lock_sync_d;
  logic [1:0]          err_sync_q, err_sync_d;
  logic                win_q, win_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                ack_q, ack_d;
  logic                rdp_q, rdp_d;
  logic                udd_q, udd_d;
  logic                ready_q, ready_d;
  logic                fail_q, fail_d;
  logic                lock_s;
  logic                err_s;

  assign lock_s = lock_sync_q[1];
  assign err_s  = err_sync_q[1];

  // Two-stage synchronisers for the asynchronous lock and refclk-domain error.
  always_comb begin
    lock_sync_d = {lock_sync_q[0], all_lock};
    err_sync_d  = {err_sync_q[0], err};
  end

  // Sequencer next state; the shared counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 13'd1;
    retry_d = retry_q;
    unique case (state_q)
      ST_WAIT_LOCK: begin
        if (!lock_s)                   cnt_d   = '0;
        else if (cnt_q == C_LOCK_LAST) state_d = ST_RESET_DP;
      end
      ST_RESET_DP: begin
        if (!lock_s)                   state_d = ST_WAIT_LOCK;
        else if (cnt_q == C_RST_LAST)  state_d = ST_WAIT_ALIGN;
      end
      ST_WAIT_ALIGN: begin
        // Losing lock is not the CSA's fault, so it is not charged as a retry.
        if (!lock_s)                                 state_d = ST_WAIT_LOCK;
        else if (err_s || (cnt_q == C_ALIGN_LAST))   state_d = ST_RETRY;
        else if (good)                               state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lock_s)             state_d = ST_WAIT_LOCK;
        else if (err_s || !good) state_d = ST_RETRY;
      end
      ST_RETRY: begin
        if (retry_q == C_MAX_RETRY) begin
          state_d = ST_FAIL;
        end else begin
          retry_d = retry_q + 4'd1;
          state_d = ST_RESET_DP;
        end
      end
      ST_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_WAIT_LOCK;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // DQSDLL update handshake: timed windows in RUN, immediate acks elsewhere.
  always_comb begin
    win_d  = win_q;
    wcnt_d = wcnt_q;
    ack_d  = 1'b0;
    if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
      if (win_q) begin
        if (wcnt_q == C_UPD_LAST) begin
          win_d  = 1'b0;
          wcnt_d = '0;
          ack_d  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end else if (upd_req) begin
        win_d  = 1'b1;
        wcnt_d = '0;
      end
    end else begin
      // Leaving RUN aborts any open window without an acknowledge.
      win_d  = 1'b0;
      wcnt_d = '0;
      if (state_q != ST_RUN) ack_d = upd_req && !ack_q;
    end
  end

  // Outputs registered from next-state so the CSA sees glitch-free controls.
  always_comb begin
    rdp_d   = !((state_d == ST_WAIT_ALIGN) || (state_d == ST_RUN));
    udd_d   = (state_d == ST_RUN) && !win_d;
    ready_d = (state_d == ST_RUN);
    fail_d  = (state_d == ST_FAIL);
  end

  // State, counters and output registers with asynchronous reset.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      retry_q     <= '0;
      lock_sync_q <= '0;
      err_sync_q  <= '0;
      win_q       <= 1'b0;
      wcnt_q      <= '0;
      ack_q       <= 1'b0;
      rdp_q       <= 1'b1;
      udd_q       <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_sync_q <= lock_sync_d;
      err_sync_q  <= err_sync_d;
      win_q       <= win_d;
      wcnt_q      <= wcnt_d;
      ack_q       <= ack_d;
      rdp_q       <= rdp_d;
      udd_q       <= udd_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign reset_datapath = rdp_q;
  assign uddcntln       = udd_q;
  assign upd_ack        = ack_q;
  assign ready          = ready_q;
  assign fail           = fail_q;
  assign retry_cnt      = retry_q;
  assign state          = state_q;

endmodule
`default_nettype wire
